// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
//   Memory-side responder for the LC-3 fetch/memory-stage request handshake.
//   Serves one access at a time from an internal 16-bit word array after a
//   fixed LATENCY. Data requests win over fetch requests at the same edge.
//   Completion is a one-cycle load pulse; read data is held until the next
//   completion on the same port.
// Ports:
//   clk, reset (async, active-low)
//   if_apply/if_addr          -> fetch request (held until if_load)
//   if_load/if_data           <- fetch completion pulse / held instruction
//   d_apply/d_we/d_addr/d_wdata -> data request (held until d_load)
//   d_load/d_rdata            <- data completion pulse / held read data
//   busy                      <- high while an access is in flight or completing
module lc3_mem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_apply,
  input  logic [15:0] if_addr,
  output logic        if_load,
  output logic [15:0] if_data,
  input  logic        d_apply,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_load,
  output logic [15:0] d_rdata,
  output logic        busy
);

  localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_FETCH, G_DATA} grant_t;

  state_t                 state_q, state_d;
  grant_t                 grant_q, grant_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   if_load_q, if_load_d;
  logic                   d_load_q, d_load_d;
  logic [15:0]            if_data_q, if_data_d;
  logic [15:0]            d_rdata_q, d_rdata_d;
  logic                   mem_we;
  logic                   granted_apply;
  logic [15:0]            mem [DEPTH];

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[15:ADDR_BITS], d_addr[15:ADDR_BITS]};

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    if_load_d     = 1'b0;
    d_load_d      = 1'b0;
    if_data_d     = if_data_q;
    d_rdata_d     = d_rdata_q;
    mem_we        = 1'b0;
    granted_apply = (grant_q == G_DATA) ? d_apply : if_apply;

    unique case (state_q)
      S_IDLE: begin
        if (d_apply) begin
          grant_d = G_DATA;
          addr_d  = d_addr[ADDR_BITS-1:0];
          we_d    = d_we;
          wdata_d = d_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end else if (if_apply) begin
          grant_d = G_FETCH;
          addr_d  = if_addr[ADDR_BITS-1:0];
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!granted_apply) begin
          // Requester withdrew: abandon without side effects.
          state_d = S_IDLE;
          grant_d = G_NONE;
        end else if (cnt_q == '0) begin
          // The array access and pulse are registered on the DONE-entry edge.
          state_d = S_DONE;
          if (grant_q == G_DATA) begin
            d_load_d = 1'b1;
            if (we_q) mem_we    = 1'b1;
            else      d_rdata_d = mem[addr_q];
          end else begin
            if_load_d = 1'b1;
            if_data_d = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      grant_q   <= G_NONE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      if_load_q <= 1'b0;
      d_load_q  <= 1'b0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      if_load_q <= if_load_d;
      d_load_q  <= d_load_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Array is not reset; mem_we is only raised from BUSY, so reset blocks writes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign if_load = if_load_q;
  assign d_load  = d_load_q;
  assign if_data = if_data_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_lc3_mem_responder.sv
module tb_lc3_mem_responder;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_apply = 1'b0, d_apply = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_load, d_load, busy;
  logic [15:0] if_data, d_rdata;

  logic        if_apply1 = 1'b0, d_apply1 = 1'b0, d_we1 = 1'b0;
  logic [15:0] if_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic        if_load1, d_load1, busy1;
  logic [15:0] if_data1, d_rdata1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: word array indexed by the aliased address, plus the
  // values each held output port should currently show.
  logic [15:0] mem_m [1024];
  logic [9:0]  written_q [$];
  logic [15:0] exp_if = '0;
  logic [15:0] exp_d  = '0;

  lc3_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .if_apply(if_apply), .if_addr(if_addr), .if_load(if_load), .if_data(if_data),
    .d_apply(d_apply), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_load(d_load), .d_rdata(d_rdata), .busy(busy)
  );

  lc3_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .if_apply(if_apply1), .if_addr(if_addr1), .if_load(if_load1), .if_data(if_data1),
    .d_apply(d_apply1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_load(d_load1), .d_rdata(d_rdata1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One access on the LATENCY=3 instance, started just after a falling edge
  // with the responder idle. abort_at>0 withdraws the request at that sample.
  task automatic do_access(input bit is_data, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input int unsigned abort_at);
    int unsigned first_n;
    int unsigned pulses;
    bit          oth_seen;
    bit          busy_ok;
    bit          dropped;
    logic [9:0]  idx;
    first_n  = 0;
    pulses   = 0;
    oth_seen = 1'b0;
    busy_ok  = 1'b1;
    dropped  = 1'b0;
    idx      = addr[9:0];
    if (is_data) begin
      d_apply = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_apply = 1'b1; if_addr = addr;
    end
    for (int unsigned n = 1; n <= LAT + 4; n++) begin
      @(negedge clk);
      if (is_data ? if_load : d_load) oth_seen = 1'b1;
      if (n == 1 && !busy) busy_ok = 1'b0;
      if (is_data ? d_load : if_load) begin
        pulses++;
        if (first_n == 0) begin
          first_n = n;
          if (is_data && !we) check("rd_data", {16'h0, d_rdata}, {16'h0, mem_m[idx]});
          if (!is_data)       check("fetch_data", {16'h0, if_data}, {16'h0, mem_m[idx]});
        end
      end
      if (!dropped && (n == abort_at || first_n != 0)) begin
        if (is_data) d_apply = 1'b0; else if_apply = 1'b0;
        dropped = 1'b1;
      end
    end
    check("busy_accept", {31'h0, busy_ok}, 32'd1);
    check("other_load", {31'h0, oth_seen}, 32'd0);
    check("busy_end", {31'h0, busy}, 32'd0);
    if (abort_at != 0) begin
      check("abort_pulses", pulses, 32'd0);
    end else begin
      check("latency", first_n, LAT + 1);
      check("pulses", pulses, 32'd1);
      if (is_data && we) begin
        mem_m[idx] = wdata;
        written_q.push_back(idx);
      end else if (is_data) begin
        exp_d = mem_m[idx];
      end else begin
        exp_if = mem_m[idx];
      end
    end
    check("if_hold", {16'h0, if_data}, {16'h0, exp_if});
    check("d_hold", {16'h0, d_rdata}, {16'h0, exp_d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned dn, fn;
    bit          coinc;
    // Reset state
    #12;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_loads", {30'h0, if_load, d_load}, 32'd0);
    check("rst_data", {if_data, d_rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Write then fetch the same word
    do_access(1'b1, 1'b1, 16'h0060, 16'h1234, 0);
    do_access(1'b0, 1'b0, 16'h0060, 16'h0000, 0);

    // Simultaneous requests: data first, fetch after one dead cycle
    do_access(1'b1, 1'b1, 16'h0061, 16'hBEEF, 0);
    d_apply = 1'b1; d_we = 1'b0; d_addr = 16'h0061;
    if_apply = 1'b1; if_addr = 16'h0060;
    dn = 0; fn = 0; coinc = 1'b0;
    for (int unsigned n = 1; n <= 2 * LAT + 8; n++) begin
      @(negedge clk);
      if (d_load && if_load) coinc = 1'b1;
      if (d_load && dn == 0) begin
        dn = n;
        check("prio_rdata", {16'h0, d_rdata}, 32'h0000BEEF);
        d_apply = 1'b0;
      end
      if (if_load && fn == 0) begin
        fn = n;
        check("prio_ifdata", {16'h0, if_data}, 32'h00001234);
        if_apply = 1'b0;
      end
    end
    check("prio_d_lat", dn, LAT + 1);
    check("prio_if_lat", fn, 2 * LAT + 3);
    check("prio_coincide", {31'h0, coinc}, 32'd0);
    exp_d = 16'hBEEF; exp_if = 16'h1234;

    // Aborts: fetch of a different word, then a write that must not commit
    do_access(1'b0, 1'b0, 16'h0061, 16'h0000, 2);
    do_access(1'b1, 1'b1, 16'h0061, 16'h5555, 1);
    do_access(1'b1, 1'b0, 16'h0061, 16'h0000, 0);

    // Aliasing of upper address bits
    do_access(1'b1, 1'b1, 16'h0005, 16'hA5A5, 0);
    do_access(1'b1, 1'b0, 16'h0405, 16'h0000, 0);

    // Asynchronous reset mid-write
    do_access(1'b1, 1'b1, 16'h0010, 16'h1111, 0);
    d_apply = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h2222;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_loads", {30'h0, if_load, d_load}, 32'd0);
    check("arst_data", {if_data, d_rdata}, 32'd0);
    d_apply = 1'b0;
    exp_if = '0; exp_d = '0;
    @(negedge clk);
    reset = 1'b1;
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 0);

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 40; i++) begin
      int unsigned op;
      logic [15:0] a;
      logic [9:0]  widx;
      op   = $urandom_range(0, 3);
      widx = written_q[$urandom_range(0, written_q.size() - 1)];
      a    = {6'($urandom), widx};
      case (op)
        0: do_access(1'b1, 1'b1, 16'($urandom), 16'($urandom), 0);
        1: do_access(1'b1, 1'b0, a, 16'h0000, 0);
        2: do_access(1'b0, 1'b0, a, 16'h0000, 0);
        default: do_access(1'($urandom), 1'($urandom), a, 16'($urandom),
                           $urandom_range(1, LAT));
      endcase
    end

    // LATENCY=1 instance: continuous fetch gives a pulse every third cycle
    if_apply1 = 1'b1; if_addr1 = 16'h0000;
    for (int unsigned n = 1; n <= 12; n++) begin
      @(negedge clk);
      check("lat1_load", {31'h0, if_load1}, {31'h0, (n % 3) == 2});
      check("lat1_busy", {31'h0, busy1}, {31'h0, (n % 3) != 0});
    end
    if_apply1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 pipeline's request/load handshake.
- Accepts instruction-fetch requests (apply + PC) from the fetch stage and data read/write requests from the memory stage.
- Arbitrates between them and serves one access at a time from an internal word array with a programmable fixed latency.
- Signals completion with a one-cycle load pulse plus held read data.

Parameters:
- ADDR_BITS, 10: internal array depth is 2^ADDR_BITS 16-bit words; address bits above this are ignored (aliasing).
- LATENCY, 3: cycles from request acceptance to load pulse; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- if_apply  in  1  fetch request; held high until if_load seen
- if_addr  in  16  fetch address (PC)
- if_load  out  1  one-cycle pulse: if_data valid
- if_data  out  16  fetched instruction word; held until next fetch completion
- d_apply  in  1  data request; held high until d_load seen
- d_we  in  1  1 = write, 0 = read; sampled at acceptance
- d_addr  in  16  data address
- d_wdata  in  16  write data; sampled at acceptance
- d_load  out  1  one-cycle pulse: data access complete (read or write)
- d_rdata  out  16  read data; held until next data read completion
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, grant=none.
  - if_load=0, d_load=0, if_data=16'h0000, d_rdata=16'h0000, busy=0.
  - Array contents are not reset.
  - Reset mid-access aborts it; no write is committed and no load pulse is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - At an edge with d_apply=1: grant=DATA; latch d_addr, d_we, d_wdata.
  - Else if if_apply=1: grant=FETCH; latch if_addr.
  - On any grant: counter=LATENCY-1, go to BUSY.
  - Data has priority over fetch when both are high at the same edge.
- BUSY:
  - If the granted port's apply is 0 at an edge: abort, go to IDLE, no pulse, no write.
  - Else if counter==0: go to DONE.
  - Else: counter decrements.
- Entering DONE (same edge):
  - FETCH: if_data = mem[addr], if_load=1.
  - DATA read: d_rdata = mem[addr], d_load=1.
  - DATA write: mem[addr] = wdata, d_load=1, d_rdata unchanged.
- DONE:
  - Lasts exactly one cycle; the load pulse is high only here.
  - Next edge returns unconditionally to IDLE; load goes back to 0.
  - A still-high apply is treated as a new request and re-evaluated in IDLE on the following edge, giving one dead cycle between back-to-back accesses.
- Latency: acceptance at edge k → load high during cycle after edge k+LATENCY.
- Address: only addr[ADDR_BITS-1:0] is used; the upper bits are ignored.
- Read data is the array value at the DONE edge. A write by the other port cannot intervene because accesses are serialized.
- Starvation: a continuously asserted d_apply starves fetch. This is acceptable; the pipeline stalls fetch during memory-stage accesses.
- The non-granted port's load stays 0 throughout, and its data output holds.
- busy=1 in BUSY and DONE, 0 in IDLE.

Test Plan:
1. LATENCY=3. Data write addr 16'h0060 = 16'h1234; then fetch if_addr=16'h0060 → d_load pulses exactly 3 cycles after acceptance; later if_load pulses 3 cycles after fetch acceptance with if_data=16'h1234, held after pulse.
2. if_apply and d_apply rise at the same edge, d_we=0, addr 16'h0061 pre-written 16'hBEEF → data served first (d_load, d_rdata=16'hBEEF); fetch accepted one dead cycle after DONE; if_load never coincides with d_load.
3. Fetch accepted, if_apply dropped after 1 cycle in BUSY → state IDLE, if_load never pulses, if_data keeps prior value; write accepted then d_apply dropped → array word unchanged on later readback.
4. Write 16'hA5A5 to 16'h0005, then read 16'h0405 (ADDR_BITS=10) → d_rdata=16'hA5A5 (aliasing).
5. reset driven low while in BUSY for a write to 16'h0010 → all outputs 0 immediately (async); after release, a readback of 16'h0010 returns the old value; next request completes with normal LATENCY.
6. LATENCY=1. Continuous if_apply → if_load pulses every 3rd cycle (accept, DONE, IDLE); busy toggles accordingly.
